parity_arbiter: RTL and testbench
=================================

PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 = even-parity convention and 1 = odd-parity convention.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to check.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_exp  input  1  requester 0 expected parity bit.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle when high together with req0_valid.
REQ-008 req1_valid, req1_data[7:0], req1_exp, req1_ready SHALL exist with the same directions, widths and meanings for requester 1.
REQ-009 res_valid  output  1  result held on res_* outputs.
REQ-010 res_ready  input  1  downstream consumes the result.
REQ-011 res_id  output  1  index of the requester whose byte produced the result.
REQ-012 res_data  output  8  the checked byte.
REQ-013 res_parity  output  1  computed parity bit.
REQ-014 res_err  output  1  res_parity differs from the captured expected bit.
REQ-015 cnt_clr  input  1  synchronous clear of both error counters.
REQ-016 err_cnt0 and err_cnt1  output  8 each  saturating error counts for requester 0 and requester 1.

Function
REQ-017 Computed parity SHALL be the XOR of all 8 data bits, inverted when PARITY_ODD=1 (0x00 gives 0 for even and 1 for odd).
REQ-018 The FSM SHALL have two states: IDLE (no result held) and RESP (result held, res_valid=1).
REQ-019 Accept condition: the block SHALL accept when state==IDLE, or when state==RESP and res_ready==1.
REQ-020 reqN_ready SHALL be asserted only for the granted requester, and only while the accept condition holds; it is combinational from the valids, last_grant, state and res_ready.
REQ-021 Grant with exactly one valid: that requester SHALL be granted.
REQ-022 Grant with both valid: the requester other than last_grant SHALL be granted (round-robin).
REQ-023 last_grant SHALL update only on an accepted transfer.
REQ-024 On a transfer (reqN_valid && reqN_ready), the next edge SHALL register res_id=N, res_data, res_parity and res_err, and move the state to RESP.
REQ-025 Latency from transfer to res_valid SHALL be 1 cycle.
REQ-026 In RESP with res_ready=1 and no transfer, the next state SHALL be IDLE.
REQ-027 In RESP with res_ready=1 and a transfer in the same cycle, the state SHALL stay RESP with new contents, giving one result per cycle.
REQ-028 In RESP with res_ready=0, all res_* outputs SHALL hold stable and both readys SHALL be 0.
REQ-029 res_* outputs SHALL change only on an accepted transfer or reset.
REQ-030 err_cntN SHALL increment by 1 on each transfer from requester N whose computed parity differs from reqN_exp.
REQ-031 err_cntN SHALL saturate at 255.
REQ-032 When cnt_clr=1, both counters SHALL become 0 on the next edge; cnt_clr SHALL win over a simultaneous increment.
REQ-033 A valid deasserted before being granted SHALL be dropped without side effects; requesters are not required to hold valid, but data SHALL be sampled only at transfer.

Reset
REQ-034 While rst_n=0, regardless of clk, the block SHALL force: state=IDLE, res_valid=0, res_id=0, res_data=0x00, res_parity=0, res_err=0, err_cnt0=0, err_cnt1=0, last_grant=1 (requester 0 wins the first contention).
REQ-035 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-036 Reset asserted mid-RESP SHALL discard the held result; no result SHALL be delivered after reset release.
REQ-037 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 Bench SHALL cover each of the following directed scenarios:
- Reset, then req0 alone with 0xA5, exp=0, PARITY_ODD=0, res_ready=1 -> next cycle res_valid=1, res_id=0, res_data=0xA5, res_parity=0, res_err=0, err_cnt0=0.
- Both valid after reset with req0 0x01 exp=0 and req1 0x03 exp=0 -> req0 granted first (res_parity=1, res_err=1, err_cnt0=1), then req1 (res_parity=0, res_err=0); both held valid -> grants alternate 0,1,0,1.
- res_ready=0 while in RESP for 5 cycles -> res_* stable, both readys 0; res_ready=1 with req1 valid -> same-cycle accept, res_valid stays 1 with new data next cycle.
- 300 consecutive req1 bytes with parity mismatch -> err_cnt1 saturates at 255; then cnt_clr=1 coincident with another mismatch -> err_cnt1=0.
- rst_n pulsed low between clock edges while in RESP -> res_valid=0 and counters=0 immediately, with no stale result after release.
- Sweep all bytes 0x00-0xFF through each requester for both PARITY_ODD values -> res_parity matches the XOR reduction (inverted for odd) for every byte.

Source files
------------

// File: rtl/parity_arbiter.sv
// -----------------------------------------------------------------------------
// parity_arbiter
//   Two-requester round-robin arbiter that checks the parity of the granted
//   byte and holds one result for a ready/valid consumer. Keeps one
//   saturating parity-error counter per requester.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/data/exp     requester N byte and its expected parity bit
//   reqN_ready              requester N byte accepted this cycle (with valid)
//   res_valid/res_ready     result handshake
//   res_id/data/parity/err  held result: source, byte, computed parity, error
//   cnt_clr                 synchronous clear of both error counters
//   err_cnt0/err_cnt1       saturating error counts per requester
// -----------------------------------------------------------------------------
module parity_arbiter #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_exp,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_exp,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [7:0] res_data,
  output logic       res_parity,
  output logic       res_err,
  input  logic       cnt_clr,
  output logic [7:0] err_cnt0,
  output logic [7:0] err_cnt1
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       res_id_q;
  logic [7:0] res_data_q;
  logic       res_parity_q;
  logic       res_err_q;
  logic [7:0] err_cnt0_q, err_cnt0_d;
  logic [7:0] err_cnt1_q, err_cnt1_d;

  logic       accept;
  logic       grant;
  logic       xfer;
  logic [7:0] xfer_data;
  logic       xfer_exp;
  logic       xfer_parity;
  logic       xfer_err;

  // Arbitration and parity of the byte being transferred this cycle.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first or full if/else); otherwise synthesis infers a latch.
  always_comb begin
    // rst_n is folded in so both readys stay low for the whole reset pulse,
    // not only after the first clock edge.
    accept = rst_n && ((state_q == IDLE) || res_ready);
    // With both valid, serve the one that did not win last time; with a
    // single valid, req1_valid alone selects requester 1.
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    req0_ready  = accept && req0_valid && !grant;
    req1_ready  = accept && req1_valid &&  grant;
    xfer        = req0_ready || req1_ready;
    xfer_data   = grant ? req1_data : req0_data;
    xfer_exp    = grant ? req1_exp  : req0_exp;
    xfer_parity = (^xfer_data) ^ PARITY_ODD;
    xfer_err    = xfer_parity != xfer_exp;
  end

  // Next state, grant history and counter updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_cnt0_d   = err_cnt0_q;
    err_cnt1_d   = err_cnt1_q;

    case (state_q)
      IDLE: if (xfer) state_d = RESP;
      RESP: begin
        // A transfer while the old result drains keeps RESP with new contents.
        if (xfer) begin
          state_d = RESP;
        end else if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      last_grant_d = grant;
    end

    // Clear takes priority over a simultaneous increment.
    if (cnt_clr) begin
      err_cnt0_d = 8'd0;
      err_cnt1_d = 8'd0;
    end else if (xfer && xfer_err) begin
      if (!grant && err_cnt0_q != 8'hFF) err_cnt0_d = err_cnt0_q + 8'd1;
      if ( grant && err_cnt1_q != 8'hFF) err_cnt1_d = err_cnt1_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      err_cnt0_q   <= 8'd0;
      err_cnt1_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_cnt0_q   <= err_cnt0_d;
      err_cnt1_q   <= err_cnt1_d;
    end
  end

  // Result registers load only on an accepted transfer and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_id_q     <= 1'b0;
      res_data_q   <= 8'h00;
      res_parity_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else if (xfer) begin
      res_id_q     <= grant;
      res_data_q   <= xfer_data;
      res_parity_q <= xfer_parity;
      res_err_q    <= xfer_err;
    end
  end

  assign res_valid  = (state_q == RESP);
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;
  assign res_parity = res_parity_q;
  assign res_err    = res_err_q;
  assign err_cnt0   = err_cnt0_q;
  assign err_cnt1   = err_cnt1_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parity_arbiter
//   Drives an even-parity and an odd-parity instance with identical stimulus.
//   A scoreboard queue receives the expected result whenever the bench's own
//   arbitration model predicts a transfer; the front entry is compared with
//   the held result after each clock edge and popped when it is consumed.
// -----------------------------------------------------------------------------
module tb_parity_arbiter;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_exp, req1_valid, req1_exp;
  logic [7:0] req0_data, req1_data;
  logic       res_ready, cnt_clr;

  logic [1:0]      req0_ready_w, req1_ready_w, res_valid_w, res_id_w;
  logic [1:0]      res_parity_w, res_err_w;
  logic [1:0][7:0] res_data_w, err_cnt0_w, err_cnt1_w;

  always #5 clk = ~clk;

  parity_arbiter #(.PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_exp(req0_exp),
    .req0_ready(req0_ready_w[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_exp(req1_exp),
    .req1_ready(req1_ready_w[0]),
    .res_valid(res_valid_w[0]), .res_ready(res_ready), .res_id(res_id_w[0]),
    .res_data(res_data_w[0]), .res_parity(res_parity_w[0]), .res_err(res_err_w[0]),
    .cnt_clr(cnt_clr), .err_cnt0(err_cnt0_w[0]), .err_cnt1(err_cnt1_w[0])
  );

  parity_arbiter #(.PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_exp(req0_exp),
    .req0_ready(req0_ready_w[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_exp(req1_exp),
    .req1_ready(req1_ready_w[1]),
    .res_valid(res_valid_w[1]), .res_ready(res_ready), .res_id(res_id_w[1]),
    .res_data(res_data_w[1]), .res_parity(res_parity_w[1]), .res_err(res_err_w[1]),
    .cnt_clr(cnt_clr), .err_cnt0(err_cnt0_w[1]), .err_cnt1(err_cnt1_w[1])
  );

  int         tests = 0;
  int         fails = 0;
  exp_t       sb[$];
  logic       lg_m;              // model of last_grant
  logic [7:0] cnt_m [2][2];      // [instance][requester]

  // Reference parity by counting ones; k=1 is the odd-parity instance.
  function automatic logic parity_ref(input logic [7:0] d, input int k);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return ((ones % 2) == 1) ^ (k != 0);
  endfunction

  task automatic model_reset();
    sb.delete();
    lg_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cnt_m[k][0] = 8'd0;
      cnt_m[k][1] = 8'd0;
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    logic ev, p;
    ev = (sb.size() != 0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (res_valid_w[k] !== ev) begin
        fails++;
        $display("FAIL %s inst%0d res_valid got %b want %b", tag, k, res_valid_w[k], ev);
      end
      if (ev) begin
        e = sb[0];
        p = parity_ref(e.data, k);
        tests++;
        if (res_id_w[k] !== e.id) begin
          fails++;
          $display("FAIL %s inst%0d res_id got %b want %b", tag, k, res_id_w[k], e.id);
        end
        tests++;
        if (res_data_w[k] !== e.data) begin
          fails++;
          $display("FAIL %s inst%0d res_data got %h want %h", tag, k, res_data_w[k], e.data);
        end
        tests++;
        if (res_parity_w[k] !== p) begin
          fails++;
          $display("FAIL %s inst%0d res_parity data %h got %b want %b", tag, k, e.data,
                   res_parity_w[k], p);
        end
        tests++;
        if (res_err_w[k] !== (p != e.exp)) begin
          fails++;
          $display("FAIL %s inst%0d res_err got %b want %b", tag, k, res_err_w[k], p != e.exp);
        end
      end
      tests++;
      if (err_cnt0_w[k] !== cnt_m[k][0]) begin
        fails++;
        $display("FAIL %s inst%0d err_cnt0 got %0d want %0d", tag, k, err_cnt0_w[k], cnt_m[k][0]);
      end
      tests++;
      if (err_cnt1_w[k] !== cnt_m[k][1]) begin
        fails++;
        $display("FAIL %s inst%0d err_cnt1 got %0d want %0d", tag, k, err_cnt1_w[k], cnt_m[k][1]);
      end
    end
  endtask

  // One clock cycle: drive inputs, check readys, advance model, check result.
  task automatic step(input string tag,
                      input logic v0, input logic [7:0] d0, input logic e0,
                      input logic v1, input logic [7:0] d1, input logic e1,
                      input logic rr, input logic clr);
    logic acc, g, r0, r1;
    exp_t ne;
    req0_valid = v0; req0_data = d0; req0_exp = e0;
    req1_valid = v1; req1_data = d1; req1_exp = e1;
    res_ready  = rr; cnt_clr   = clr;
    #1;
    acc = (sb.size() == 0) || rr;
    g   = (v0 && v1) ? !lg_m : v1;
    r0  = acc && v0 && !g;
    r1  = acc && v1 &&  g;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (req0_ready_w[k] !== r0 || req1_ready_w[k] !== r1) begin
        fails++;
        $display("FAIL %s inst%0d readys got %b%b want %b%b", tag, k,
                 req1_ready_w[k], req0_ready_w[k], r1, r0);
      end
    end
    if (sb.size() != 0 && rr) void'(sb.pop_front());
    if (r0 || r1) begin
      ne.id   = g;
      ne.data = g ? d1 : d0;
      ne.exp  = g ? e1 : e0;
      sb.push_back(ne);
      lg_m = g;
      for (int k = 0; k < 2; k++) begin
        if (!clr && parity_ref(ne.data, k) != ne.exp && cnt_m[k][g] != 8'hFF)
          cnt_m[k][g] = cnt_m[k][g] + 8'd1;
      end
    end
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        cnt_m[k][0] = 8'd0;
        cnt_m[k][1] = 8'd0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; cnt_clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hFF; req0_exp = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hFF; req1_exp = 1'b0;
    res_ready = 1'b1; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (req0_ready_w[k] !== 1'b0 || req1_ready_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset inst%0d readys got %b%b want 00", k, req1_ready_w[k], req0_ready_w[k]);
      end
      tests++;
      if ({res_valid_w[k], res_id_w[k], res_data_w[k], res_parity_w[k], res_err_w[k]} !== 12'h000) begin
        fails++;
        $display("FAIL reset inst%0d res got v%b id%b d%h p%b e%b want all zero", k,
                 res_valid_w[k], res_id_w[k], res_data_w[k], res_parity_w[k], res_err_w[k]);
      end
      tests++;
      if (err_cnt0_w[k] !== 8'd0 || err_cnt1_w[k] !== 8'd0) begin
        fails++;
        $display("FAIL reset inst%0d counters got %0d/%0d want 0/0", k, err_cnt0_w[k], err_cnt1_w[k]);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    // First transfer on the first edge after release.
    step("basic_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("basic_drain", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    int exp_ids [4] = '{0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step("rr_both", 1'b1, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
      tests++;
      if (res_id_w[0] !== exp_ids[i][0]) begin
        fails++;
        $display("FAIL rr_order cycle%0d res_id got %b want %0d", i, res_id_w[0], exp_ids[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] snap;
    snap = res_data_w[0];
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b1, 8'h77, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0);
      tests++;
      if (res_data_w[0] !== snap) begin
        fails++;
        $display("FAIL hold_stable cycle%0d res_data got %h want %h", i, res_data_w[0], snap);
      end
    end
    step("same_cycle", 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    // A single requester cycling valid without ever being granted, then gone.
    step("drop", 1'b0, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    step("drop_gone", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++)
      step("sat", 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    tests++;
    if (err_cnt1_w[0] !== 8'd255) begin
      fails++;
      $display("FAIL sat_255 err_cnt1 got %0d want 255", err_cnt1_w[0]);
    end
    step("clr_wins", 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    tests++;
    if (err_cnt1_w[0] !== 8'd0) begin
      fails++;
      $display("FAIL clr_wins err_cnt1 got %0d want 0", err_cnt1_w[0]);
    end
  endtask

  task automatic test_reset_mid_resp();
    step("pre_rst", 1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (res_valid_w[k] !== 1'b0 || err_cnt0_w[k] !== 8'd0 || err_cnt1_w[k] !== 8'd0 ||
          req0_ready_w[k] !== 1'b0 || req1_ready_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL rst_async inst%0d v%b c0=%0d c1=%0d rdy%b%b want all zero", k,
                 res_valid_w[k], err_cnt0_w[k], err_cnt1_w[k], req1_ready_w[k], req0_ready_w[k]);
      end
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    step("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("post_rst_idle2", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sweep();
    logic [7:0] b;
    logic       e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) begin
        b = i[7:0];
        e = 1'($urandom_range(0, 1));
        if (r == 0) step("sweep0", 1'b1, b, e, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        else        step("sweep1", 1'b0, 8'h00, 1'b0, 1'b1, b, e, 1'b1, 1'b0);
      end
    end
    step("sweep_drain", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_saturate();
    test_reset_mid_resp();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
